// File: rtl/udc_seq_monitor.sv
// Checks that a 3-bit up/down counter steps by exactly one in its commanded direction,
// counting verified wraps and latching a sticky fault on the first out-of-sequence value.
module udc_seq_monitor #(
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned MIS_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              x,
    input  logic              q2,
    input  logic              q1,
    input  logic              q0,
    input  logic              clr,
    output logic              valid,
    output logic [2:0]        exp_q,
    output logic              err,
    output logic              err_pulse,
    output logic [MIS_W-1:0]  mis_cnt,
    output logic [WRAP_W-1:0] up_wraps,
    output logic [WRAP_W-1:0] dn_wraps,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        StSync  = 2'b00,
        StTrack = 2'b01,
        StFault = 2'b10
    } state_e;

    localparam logic [WRAP_W-1:0] WrapMax = '1;
    localparam logic [MIS_W-1:0]  MisMax  = '1;

    state_e            state_q, state_d;
    logic [2:0]        exp_d;
    logic              dir_q, dir_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              pulse_q, pulse_d;
    logic [MIS_W-1:0]  mis_q, mis_d;
    logic [WRAP_W-1:0] up_q, up_d;
    logic [WRAP_W-1:0] dn_q, dn_d;

    logic [2:0] q;
    logic [2:0] pred;

    assign q    = {q2, q1, q0};
    assign pred = x ? (q - 3'd1) : (q + 3'd1);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        err_d   = err_q;
        pulse_d = 1'b0;
        mis_d   = mis_q;
        up_d    = up_q;
        dn_d    = dn_q;
        if (clr) begin
            state_d = StSync;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                StSync: begin
                    exp_d   = pred;
                    dir_d   = x;
                    state_d = StTrack;
                    valid_d = 1'b1;
                end
                StTrack: begin
                    if (q == exp_q) begin
                        exp_d = pred;
                        dir_d = x;
                        // exp_q/dir_q identify the source of the verified step: 7 up or 0 down
                        if (exp_q == 3'd0 && !dir_q && up_q != WrapMax) begin
                            up_d = up_q + WRAP_W'(1);
                        end
                        if (exp_q == 3'd7 && dir_q && dn_q != WrapMax) begin
                            dn_d = dn_q + WRAP_W'(1);
                        end
                    end else begin
                        pulse_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = StFault;
                        valid_d = 1'b0;
                        if (mis_q != MisMax) begin
                            mis_d = mis_q + MIS_W'(1);
                        end
                    end
                end
                StFault: begin
                end
                default: begin
                    state_d = StSync;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StSync;
            exp_q   <= 3'd0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            pulse_q <= 1'b0;
            mis_q   <= '0;
            up_q    <= '0;
            dn_q    <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
            mis_q   <= mis_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    assign valid     = valid_q;
    assign err       = err_q;
    assign err_pulse = pulse_q;
    assign mis_cnt   = mis_q;
    assign up_wraps  = up_q;
    assign dn_wraps  = dn_q;
    assign state     = state_q;

endmodule

// File: tb/tb_udc_seq_monitor.sv
// Drives two monitors (default and narrow counters) from a behavioural up/down counter with
// injected faults, clears and resets, and compares every output against a history-based model.
module tb_udc_seq_monitor;

    localparam int BW_W = 8, BM_W = 4;
    localparam int SW_W = 2, SM_W = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x = 1'b0, clr = 1'b0;
    logic q2 = 1'b0, q1 = 1'b0, q0 = 1'b0;

    logic            b_valid, b_err, b_pulse;
    logic [2:0]      b_exp;
    logic [BM_W-1:0] b_mis;
    logic [BW_W-1:0] b_up, b_dn;
    logic [1:0]      b_state;

    logic            s_valid, s_err, s_pulse;
    logic [2:0]      s_exp;
    logic [SM_W-1:0] s_mis;
    logic [SW_W-1:0] s_up, s_dn;
    logic [1:0]      s_state;

    always #5 clk = ~clk;

    udc_seq_monitor #(.WRAP_W(BW_W), .MIS_W(BM_W)) u_big (
        .clk(clk), .reset(reset), .x(x), .q2(q2), .q1(q1), .q0(q0), .clr(clr),
        .valid(b_valid), .exp_q(b_exp), .err(b_err), .err_pulse(b_pulse),
        .mis_cnt(b_mis), .up_wraps(b_up), .dn_wraps(b_dn), .state(b_state)
    );

    udc_seq_monitor #(.WRAP_W(SW_W), .MIS_W(SM_W)) u_small (
        .clk(clk), .reset(reset), .x(x), .q2(q2), .q1(q1), .q0(q0), .clr(clr),
        .valid(s_valid), .exp_q(s_exp), .err(s_err), .err_pulse(s_pulse),
        .mis_cnt(s_mis), .up_wraps(s_up), .dn_wraps(s_dn), .state(s_state)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Reference: mode 0 SYNC / 1 TRACK / 2 FAULT; the last verified sample (src) fixes the
    // prediction; counters are kept unbounded and clamped when compared.
    int  cnt = 0;
    int  m_mode = 0;
    bit  m_have = 0;
    int  src_q = 0;
    bit  src_x = 0;
    bit  m_err = 0, m_pulse = 0;
    int  mis_raw = 0, up_raw = 0, dn_raw = 0;

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic int next_of(input int v, input bit dn);
        return dn ? (v + 7) % 8 : (v + 1) % 8;
    endfunction

    task automatic check(input string tag, input int obs, input int exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model(input bit rst, input bit xi, input bit ci, input int qv);
        m_pulse = 0;
        if (rst) begin
            m_mode = 0; m_have = 0; m_err = 0;
            mis_raw = 0; up_raw = 0; dn_raw = 0;
        end else if (ci) begin
            m_mode = 0; m_err = 0;
        end else if (m_mode == 0) begin
            src_q = qv; src_x = xi; m_have = 1; m_mode = 1;
        end else if (m_mode == 1) begin
            if (qv == next_of(src_q, src_x)) begin
                if (src_q == 7 && !src_x) up_raw++;
                if (src_q == 0 && src_x) dn_raw++;
                src_q = qv; src_x = xi;
            end else begin
                m_pulse = 1; m_err = 1; mis_raw++; m_mode = 2;
            end
        end
    endtask

    task automatic check_all();
        int e_exp;
        e_exp = m_have ? next_of(src_q, src_x) : 0;
        check("big.state", int'(b_state), m_mode);
        check("big.valid", int'(b_valid), int'(m_mode == 1));
        check("big.exp_q", int'(b_exp), e_exp);
        check("big.err", int'(b_err), int'(m_err));
        check("big.err_pulse", int'(b_pulse), int'(m_pulse));
        check("big.mis_cnt", int'(b_mis), sat(mis_raw, BM_W));
        check("big.up_wraps", int'(b_up), sat(up_raw, BW_W));
        check("big.dn_wraps", int'(b_dn), sat(dn_raw, BW_W));
        check("small.state", int'(s_state), m_mode);
        check("small.exp_q", int'(s_exp), e_exp);
        check("small.err_pulse", int'(s_pulse), int'(m_pulse));
        check("small.mis_cnt", int'(s_mis), sat(mis_raw, SM_W));
        check("small.up_wraps", int'(s_up), sat(up_raw, SW_W));
        check("small.dn_wraps", int'(s_dn), sat(dn_raw, SW_W));
    endtask

    // fq < 0 presents the true counter value; otherwise fq is forced onto q for one cycle.
    task automatic step(input bit rst, input bit xi, input bit ci, input int fq);
        logic [2:0] qv;
        qv = (fq >= 0) ? 3'(fq) : 3'(cnt);
        reset = rst; x = xi; clr = ci; {q2, q1, q0} = qv;
        @(posedge clk);
        #1;
        model(rst, xi, ci, int'(qv));
        cnt = rst ? 0 : next_of(cnt, xi);
        check_all();
    endtask

    initial begin
        // Count up from reset
        step(1, 0, 0, -1);
        step(1, 0, 0, -1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, -1);
        check("up.up_wraps", int'(b_up), 1);
        check("up.dn_wraps", int'(b_dn), 0);

        // Count down from reset
        step(1, 1, 0, -1);
        for (int i = 0; i < 9; i++) step(0, 1, 0, -1);
        check("down.err", int'(b_err), 0);

        // Direction reversal: up to 5, down 4, up again
        step(1, 0, 0, -1);
        while (cnt != 5) step(0, 0, 0, -1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, -1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, -1);
        check("rev.err", int'(b_err), 0);

        // Fault injection, then clear
        step(1, 0, 0, -1);
        while (cnt != 4) step(0, 0, 0, -1);
        step(0, 0, 0, 6);
        check("fault.pulse", int'(b_pulse), 1);
        check("fault.state", int'(b_state), 2);
        check("fault.mis_cnt", int'(b_mis), 1);
        step(0, 0, 0, -1);
        check("fault.pulse_off", int'(b_pulse), 0);
        step(0, 0, 1, -1);
        check("clr.state", int'(b_state), 0);
        step(0, 0, 0, -1);
        check("clr.resume", int'(b_state), 1);
        check("clr.mis_kept", int'(b_mis), 1);

        // Clear and mismatch in the same cycle: clear wins
        step(0, 0, 0, -1);
        step(0, 0, 1, (cnt + 3) % 8);
        check("clrwin.pulse", int'(b_pulse), 0);

        // Saturation: many up-wraps and repeated faults
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 14; i++) step(0, 0, 0, -1);
            step(0, 0, 0, (cnt + 2) % 8);
            step(0, 0, 1, -1);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, -1);
        check("sat.small_up", int'(s_up), 3);
        check("sat.small_mis", int'(s_mis), 1);

        // Reset mid-TRACK
        step(1, 0, 0, -1);
        check("rst.up", int'(b_up), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, -1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            bit xi, ci, ri;
            int fq;
            if ($urandom_range(0, 9) == 0) xi = ~x; else xi = x;
            ci = ($urandom_range(0, 19) == 0);
            ri = ($urandom_range(0, 99) == 0);
            fq = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 7)) : -1;
            step(ri, xi, ci, fq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
